mvm_stream_loader: RTL and testbench
====================================

# mvm_stream_loader

Sequential front/back end for the combinational matrix-vector multiplier. Accepts operands one element per handshake over a single WIDTH-bit stream and assembles them into the parallel matrix and vector buses that drive the multiplier. Waits a fixed number of settle cycles, captures the multiplier's parallel result, then streams the ROWS result elements out over a valid/ready interface. It sits between the board-level stimulus (switches, or a future UART/memory reader) and the multiplier instance.

## Interface
Parameters:
- WIDTH, 32, element width in bits (fixed-point, passed through untouched)
- FRAC, 8, fractional bits; carried for consistency with the multiplier only, no arithmetic performed here
- ROWS, 2, matrix rows = result length
- COLS, 2, matrix columns = input vector length
- SETTLE_CYCLES, 1, cycles allowed for the combinational multiplier path (≥1)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  WIDTH  operand element
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- mat_o  out  WIDTH×[ROWS][COLS]  assembled matrix to multiplier
- vec_o  out  WIDTH×[COLS]  assembled vector to multiplier
- res_i  in  WIDTH×[ROWS]  multiplier result
- out_data  out  WIDTH  result element
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- busy  out  1  a transaction is in progress

## Operation
- States: LOAD_MAT → LOAD_VEC → SETTLE → DRAIN → LOAD_MAT.
- Accept = in_valid && in_ready. in_ready = 1 only in LOAD_MAT and LOAD_VEC, and 0 while reset is high.
- LOAD_MAT: element k (0..ROWS·COLS−1) on the k-th accept is written to mat_o[k / COLS][k % COLS] (row-major). After accept of k = ROWS·COLS−1 → LOAD_VEC, index cleared.
- LOAD_VEC: element c on the c-th accept is written to vec_o[c]. After accept of c = COLS−1 → SETTLE.
- SETTLE: a counter runs SETTLE_CYCLES cycles. At the final SETTLE edge, res_i is latched into an internal result register. State → DRAIN, out index = 0.
- DRAIN: out_valid = 1 and out_data = result[out index]. Both stay stable until out_ready. On out_valid && out_ready, the index increments. After the handshake at index ROWS−1 → LOAD_MAT, index cleared.
- mat_o and vec_o change only on accepts. They hold their values through SETTLE, DRAIN and the start of the next load. Partially reloaded operands are acceptable because the result is already latched.
- in_valid outside the load states is ignored. No data is dropped because in_ready = 0.
- busy = 0 only in LOAD_MAT with the index at 0; otherwise 1.
- No arithmetic, saturation or width conversion is performed in this block.

## Timing
- Reset (reset high at an edge): state = LOAD_MAT and all indices = 0. mat_o, vec_o, the result register and out_data = 0. out_valid = 0, busy = 0, in_ready = 0 while reset is high. in_ready = 1 on the first cycle after reset deasserts.
- Reset mid-transaction (any state) aborts it. Partially loaded operands and undelivered results are cleared, with no further output.
- Accept throughput: one element per cycle while in_valid is held high. No bubble between LOAD_MAT and LOAD_VEC.
- If the last vector element is accepted at edge T:
  - SETTLE occupies cycles T+1 … T+SETTLE_CYCLES.
  - res_i is sampled at edge T+SETTLE_CYCLES.
  - out_valid rises in the cycle following that edge.
- Drain throughput: one element per cycle with out_ready tied high.
- The first cycle after the final drain handshake has in_ready = 1.
- Minimum transaction with SETTLE_CYCLES = 1 and continuous valid/ready: ROWS·COLS + COLS + 1 + ROWS cycles.
- out_valid never deasserts without a handshake, except on reset.

## Test plan
- Basic, WIDTH=32, FRAC=8, ROWS=COLS=2, real multiplier attached:
  - Stream 0x100, 0x200, 0x300, 0x400, then 0x100, 0x100 with out_ready=1.
  - Expect mat_o = {{0x100,0x200},{0x300,0x400}} and vec_o = {0x100,0x100}.
  - Expect out_data 0x300 then 0x700 on consecutive cycles, with out_valid rising 2 cycles after the last accept edge.
- Input gaps: insert random in_valid=0 cycles between the same six elements.
  - Expect an identical result, and mat_o/vec_o updating only on accept cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DRAIN.
  - Expect out_valid=1 and out_data=0x300 stable throughout.
  - Expect in_ready=0 and in_valid pulses ignored.
  - Release → 0x300 then 0x700, then in_ready=1.
- Mid-load reset: assert reset for 1 cycle after 3 matrix elements.
  - Expect all outputs 0, busy=0, in_ready=1 next cycle.
  - A fresh 6-element load then produces the correct result with no residue.
- SETTLE_CYCLES=3: with continuous handshakes, expect out_valid to rise exactly 4 cycles after the last accept edge, and busy=1 throughout.
- Back-to-back transactions: start the second load on the cycle after the final drain handshake.
  - Expect the second result to reflect only the second operand set.
  - Expect busy to drop for exactly the idle cycles between transactions.

Source files
------------

// File: rtl/mvm_stream_loader.sv
// Serial front/back end for the combinational matrix-vector multiplier: gathers operands
// element by element, lets the multiplier settle, latches its result and streams it out.
module mvm_stream_loader #(
  parameter int WIDTH         = 32,
  parameter int FRAC          = 8,
  parameter int ROWS          = 2,
  parameter int COLS          = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [WIDTH-1:0]                       in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]   mat_o,
  output logic [COLS-1:0][WIDTH-1:0]             vec_o,
  input  logic [ROWS-1:0][WIDTH-1:0]             res_i,
  output logic [WIDTH-1:0]                       out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // FRAC only documents the multiplier's number format; reject nonsensical settings early.
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
    $error("FRAC must lie within the element width");
  end

  typedef enum logic [1:0] {
    LOAD_MAT,
    LOAD_VEC,
    SETTLE,
    DRAIN
  } state_t;

  state_t                      state;
  state_t                      state_n;
  logic [ROW_W-1:0]            row_idx;
  logic [COL_W-1:0]            col_idx;
  logic [ROW_W-1:0]            out_idx;
  logic [CNT_W-1:0]            settle_cnt;
  logic [ROWS-1:0][WIDTH-1:0]  result_q;

  logic accept;
  logic row_last;
  logic col_last;
  logic out_last;
  logic settle_last;

  assign in_ready    = !reset && (state == LOAD_MAT || state == LOAD_VEC);
  assign accept      = in_valid && in_ready;
  assign row_last    = (row_idx == ROW_LAST);
  assign col_last    = (col_idx == COL_LAST);
  assign out_last    = (out_idx == ROW_LAST);
  assign settle_last = (settle_cnt == CNT_LAST);

  assign out_valid = (state == DRAIN);
  assign out_data  = result_q[out_idx];
  assign busy      = !(state == LOAD_MAT && row_idx == '0 && col_idx == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD_MAT;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LOAD_MAT: if (accept && row_last && col_last) state_n = LOAD_VEC;
      LOAD_VEC: if (accept && col_last)             state_n = SETTLE;
      SETTLE:   if (settle_last)                    state_n = DRAIN;
      DRAIN:    if (out_ready && out_last)          state_n = LOAD_MAT;
      default:                                      state_n = LOAD_MAT;
    endcase
  end

  // Operand buses move only on accepts, so the multiplier inputs stay put while it settles
  // and while the latched result drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_idx    <= '0;
      col_idx    <= '0;
      out_idx    <= '0;
      settle_cnt <= '0;
      mat_o      <= '0;
      vec_o      <= '0;
      result_q   <= '0;
    end else begin
      unique case (state)
        LOAD_MAT: begin
          if (accept) begin
            mat_o[row_idx][col_idx] <= in_data;
            if (col_last) begin
              col_idx <= '0;
              row_idx <= row_last ? '0 : row_idx + 1'b1;
            end else begin
              col_idx <= col_idx + 1'b1;
            end
          end
        end
        LOAD_VEC: begin
          if (accept) begin
            vec_o[col_idx] <= in_data;
            col_idx        <= col_last ? '0 : col_idx + 1'b1;
            settle_cnt     <= '0;
          end
        end
        SETTLE: begin
          if (settle_last) begin
            result_q   <= res_i;
            out_idx    <= '0;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_idx <= out_last ? '0 : out_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_stream_loader.sv
// Scoreboard bench for mvm_stream_loader with a fixed-point multiplier model attached;
// a second instance runs with a longer settle window.
module tb_mvm_stream_loader;

  localparam int WIDTH = 32;
  localparam int FRAC  = 8;
  localparam int ROWS  = 2;
  localparam int COLS  = 2;

  typedef logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] mat_t;
  typedef logic [COLS-1:0][WIDTH-1:0]           vec_t;
  typedef logic [ROWS-1:0][WIDTH-1:0]           res_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  mat_t             mat_o;
  vec_t             vec_o;
  res_t             res_i;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             busy;

  logic [WIDTH-1:0] in_data3 = '0;
  logic             in_valid3 = 1'b0;
  logic             in_ready3;
  mat_t             mat3;
  vec_t             vec3;
  res_t             res3;
  logic [WIDTH-1:0] out_data3;
  logic             out_valid3;
  logic             out_ready3 = 1'b1;
  logic             busy3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [WIDTH-1:0] expq[$];
  logic [WIDTH-1:0] expq3[$];
  int               pop_cyc[$];
  int               busy_low = 0;

  logic [WIDTH-1:0] set_a[6] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h100, 32'h100};
  logic [WIDTH-1:0] set_b[6] = '{32'h100, 32'h000, 32'h000, 32'h100, 32'h500, 32'h200};
  logic [WIDTH-1:0] set_c[6] = '{32'h200, 32'h000, 32'h000, 32'h100, 32'h300, 32'h100};

  mvm_stream_loader #(.WIDTH(WIDTH), .FRAC(FRAC), .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mat_o(mat_o), .vec_o(vec_o), .res_i(res_i), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  mvm_stream_loader #(.WIDTH(WIDTH), .FRAC(FRAC), .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mat_o(mat3), .vec_o(vec3), .res_i(res3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .busy(busy3)
  );

  // Fixed-point multiplier stand-in: signed dot product per row, rescaled by FRAC bits.
  function automatic res_t mvm(mat_t m, vec_t v);
    res_t res;
    logic signed [2*WIDTH-1:0] acc;
    for (int i = 0; i < ROWS; i++) begin
      acc = '0;
      for (int j = 0; j < COLS; j++) begin
        acc += $signed(m[i][j]) * $signed(v[j]);
      end
      res[i] = WIDTH'(acc >>> FRAC);
    end
    return res;
  endfunction

  always_comb res_i = mvm(mat_o, vec_o);
  always_comb res3  = mvm(mat3, vec3);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one element after an optional idle gap and hold it until it is accepted.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input int gap);
    logic rdy;
    bit done;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      done = rdy;
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic loadSet(input logic [WIDTH-1:0] e[6], input int max_gap);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(e[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      #2;
      done = (expq.size() == 0) && !out_valid;
    end
    if (!done) checkOutput("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops on handshakes plus protocol invariants sampled every falling edge.
  logic             prev_reset = 1'b1;
  logic             prev_acc = 1'b0;
  logic             prev_valid = 1'b0;
  logic             prev_ready = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  mat_t             prev_mat;
  vec_t             prev_vec;
  int               accept_cnt = 0;
  int               drain_cnt = 0;
  int               last_acc_cyc = 0;
  bit               expect_ready = 1'b0;

  always @(negedge clk) begin
    logic acc;
    logic [WIDTH-1:0] exp;
    acc = in_valid && in_ready;
    if (reset) begin
      accept_cnt   = 0;
      drain_cnt    = 0;
      expect_ready = 1'b0;
      prev_valid   = 1'b0;
    end else begin
      if (!prev_reset && (mat_o !== prev_mat || vec_o !== prev_vec))
        checkOutput("operands_change_only_on_accept", prev_acc, 1);
      if (expect_ready) checkOutput("in_ready_after_drain", in_ready, 1);
      expect_ready = 1'b0;
      if (!busy) busy_low++;
      if (acc) begin
        accept_cnt++;
        if (accept_cnt % 6 == 0) last_acc_cyc = cyc;
      end
      if (out_valid && !prev_valid) checkOutput("valid_latency", cyc - last_acc_cyc, 2);
      if (prev_valid && !prev_ready) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_data", out_data, prev_data);
      end
      if (out_valid) begin
        checkOutput("in_ready_low_in_drain", in_ready, 0);
        checkOutput("busy_in_drain", busy, 1);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_output", out_data, 0);
        end else begin
          exp = expq.pop_front();
          checkOutput("out_data", out_data, exp);
          pop_cyc.push_back(cyc);
        end
        drain_cnt++;
        if (drain_cnt % ROWS == 0) expect_ready = 1'b1;
      end
      prev_valid = out_valid;
    end
    prev_reset = reset;
    prev_acc   = acc;
    prev_ready = out_ready;
    prev_data  = out_data;
    prev_mat   = mat_o;
    prev_vec   = vec_o;
  end

  always @(negedge clk) begin
    logic [WIDTH-1:0] exp;
    if (!reset && out_valid3 && out_ready3) begin
      if (expq3.size() == 0) begin
        checkOutput("s3_unexpected_output", out_data3, 0);
      end else begin
        exp = expq3.pop_front();
        checkOutput("s3_out_data", out_data3, exp);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    mat_t exp_mat;
    vec_t exp_vec;
    int   n;
    bit   seen;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_mat", mat_o, 0);
    checkOutput("reset_vec", vec_o, 0);
    checkOutput("reset_out_data", out_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // Basic transaction: rows (1,2)*(1,1)=3 and (3,4)*(1,1)=7 in Q8
    expq.push_back(32'h300);
    expq.push_back(32'h700);
    pop_cyc.delete();
    loadSet(set_a, 0);
    @(negedge clk);
    exp_mat[0][0] = 32'h100;
    exp_mat[0][1] = 32'h200;
    exp_mat[1][0] = 32'h300;
    exp_mat[1][1] = 32'h400;
    exp_vec[0]    = 32'h100;
    exp_vec[1]    = 32'h100;
    checkOutput("basic_mat", mat_o, exp_mat);
    checkOutput("basic_vec", vec_o, exp_vec);
    waitDrain();
    if (pop_cyc.size() == 2) checkOutput("drain_back_to_back", pop_cyc[1] - pop_cyc[0], 1);
    else checkOutput("drain_count", pop_cyc.size(), 2);

    // Same operands with random idle gaps between elements
    expq.push_back(32'h300);
    expq.push_back(32'h700);
    loadSet(set_a, 3);
    waitDrain();

    // Backpressure: downstream stalls for five cycles while stray in_valid pulses arrive
    out_ready = 1'b0;
    expq.push_back(32'h300);
    expq.push_back(32'h700);
    loadSet(set_a, 0);
    seen = 1'b0;
    for (n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid;
    end
    checkOutput("bp_reached_drain", seen, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_data  = 32'hdead;
      @(negedge clk);
      checkOutput("bp_out_data_stable", out_data, 32'h300);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("bp_mat_untouched", mat_o, exp_mat);
    out_ready = 1'b1;
    waitDrain();

    // Reset after three matrix elements aborts the load entirely
    applyStimulus(32'h900, 0);
    applyStimulus(32'ha00, 0);
    applyStimulus(32'hb00, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_mat", mat_o, 0);
    checkOutput("midreset_vec", vec_o, 0);
    checkOutput("midreset_out_data", out_data, 0);
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    // (2,0)*(3,1)=6 and (0,1)*(3,1)=1
    expq.push_back(32'h600);
    expq.push_back(32'h100);
    loadSet(set_c, 0);
    waitDrain();

    // Back-to-back: second load starts the cycle after the final drain handshake
    expq.push_back(32'h300);
    expq.push_back(32'h700);
    expq.push_back(32'h500);
    expq.push_back(32'h200);
    loadSet(set_a, 0);
    busy_low = 0;
    seen = 1'b0;
    for (n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      #2;
      seen = (expq.size() == 2);
    end
    checkOutput("b2b_first_drained", seen, 1);
    @(posedge clk);
    #1;
    loadSet(set_b, 0);
    checkOutput("b2b_busy_low_cycles", busy_low, 1);
    waitDrain();

    // SETTLE_CYCLES = 3 instance: continuous load, latency 4, busy held throughout
    expq3.push_back(32'h300);
    expq3.push_back(32'h700);
    in_valid3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data3 = set_a[k];
      @(negedge clk);
      checkOutput("s3_in_ready", in_ready3, 1);
      @(posedge clk);
      #1;
    end
    in_valid3 = 1'b0;
    seen = 1'b0;
    n = 0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      seen = out_valid3;
      checkOutput("s3_busy", busy3, 1);
    end
    checkOutput("s3_valid_latency", n, 4);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      #2;
      seen = (expq3.size() == 0);
    end
    checkOutput("s3_drained", seen, 1);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
